// File: rtl/signed_mac_accum_if.sv
// Product-in / frame-result-out stream bundle for signed_mac_accum.
// master = producer/consumer side, slave = the accumulator.
interface signed_mac_accum_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       p_in;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_sat;

  modport master (
    output in_valid, p_in, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, p_in, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );
endinterface

// File: rtl/signed_mac_accum.sv
// Saturating signed frame accumulator for 8-bit products; result one cycle after the closing beat.
// Backpressure: in_ready drops for every cycle a result is pending, so each frame costs one bubble.
module signed_mac_accum #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  signed_mac_accum_if.slave   bus
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;
  logic [ACC_W-1:0]  r_out_data;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_sat;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_take;
  logic [ACC_W:0]    w_sum;
  logic              w_ovf;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_sat_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_close;

  // One guard bit is enough: |acc| + |p_in| never exceeds 2^ACC_W for ACC_W >= 8.
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-7){bus.p_in[7]}}, bus.p_in};
  assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_nxt = w_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
  assign w_sat_nxt = r_sat | w_ovf;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_close   = bus.in_last | (w_cnt_inc == CNT_W'(MAX_TERMS));

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_take    = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_ACC: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_close) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_ACC;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_inc;
      r_sat <= w_sat_nxt;
      if (w_close) begin
        r_out_data  <= w_acc_nxt;
        r_out_count <= w_cnt_inc;
        r_out_sat   <= w_sat_nxt;
      end
    end else if (w_take) begin
      // Result registers keep the last frame; only the running state clears.
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;

endmodule
